// File: rtl/pixel_array_digital.sv
// Digital back-end of the 2x2 pixel array: per-pixel ramp-code capture on comparator trip,
// saturation fill, and read-out over the pixel data buses under the erase/convert/read protocol.
module pixel_array_digital #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] SAT_CODE    = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       erase,
    input  logic       convert,
    input  logic       read,
    input  logic [7:0] ramp_code,
    input  logic [3:0] cmp,
    output logic [7:0] pix_data1,
    output logic [7:0] pix_data2,
    output logic [7:0] pix_data3,
    output logic [7:0] pix_data4,
    output logic       pix_oe,
    output logic [3:0] pix_sat,
    output logic       done,
    output logic       proto_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_ERASE, S_ARMED, S_CONVERT, S_DONE, S_READ
    } state_t;

    state_t state, state_nxt;
    logic   err_set;

    // cmp synchronizer and matching ramp/convert delay lines keep the code aligned with the trip
    logic [3:0]             cmp_p  [SYNC_STAGES];
    logic [7:0]             ramp_p [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] conv_p;
    logic                   conv_q;
    logic                   conv_d;
    logic                   conv_fall;

    logic [7:0] data_q [4];
    logic [3:0] captured;
    logic [3:0] sat_q;
    logic       done_q;
    logic       err_q;

    assign conv_d    = conv_p[SYNC_STAGES-1];
    assign conv_fall = conv_q & ~conv_d;

    always_ff @(posedge clk) begin
        if (reset || erase) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                cmp_p[i]  <= '0;
                ramp_p[i] <= '0;
            end
            conv_p <= '0;
            conv_q <= 1'b0;
        end else begin
            cmp_p[0]  <= cmp;
            ramp_p[0] <= ramp_code;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                cmp_p[i]  <= cmp_p[i-1];
                ramp_p[i] <= ramp_p[i-1];
            end
            conv_p <= {conv_p[SYNC_STAGES-2:0], convert};
            conv_q <= conv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        if (erase) begin
            state_nxt = S_ERASE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (convert || read) err_set = 1'b1;
                end
                S_ERASE: state_nxt = S_ARMED;
                S_ARMED: begin
                    if (convert)   state_nxt = S_CONVERT;
                    else if (read) err_set = 1'b1;
                end
                S_CONVERT: begin
                    if (conv_fall) state_nxt = S_DONE;
                end
                S_DONE: begin
                    if (convert)   err_set = 1'b1;
                    else if (read) state_nxt = S_READ;
                end
                S_READ: begin
                    if (!read) state_nxt = S_DONE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // First trip wins; pixels still untripped when convert ends are filled with SAT_CODE
    always_ff @(posedge clk) begin
        if (reset || erase) begin
            for (int i = 0; i < 4; i++) data_q[i] <= '0;
            captured <= '0;
            sat_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (err_set) err_q <= 1'b1;
            if (state == S_CONVERT) begin
                if (conv_fall) begin
                    for (int i = 0; i < 4; i++) begin
                        if (!captured[i]) begin
                            data_q[i] <= SAT_CODE;
                            sat_q[i]  <= 1'b1;
                        end
                    end
                    done_q <= 1'b1;
                end else if (conv_d) begin
                    for (int i = 0; i < 4; i++) begin
                        if (cmp_p[SYNC_STAGES-1][i] && !captured[i]) begin
                            data_q[i]   <= ramp_p[SYNC_STAGES-1];
                            captured[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign pix_data1 = data_q[0];
    assign pix_data2 = data_q[1];
    assign pix_data3 = data_q[2];
    assign pix_data4 = data_q[3];
    assign pix_oe    = (state == S_READ);
    assign pix_sat   = sat_q;
    assign done      = done_q;
    assign proto_err = err_q;

endmodule
